// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: shared widths, ALU op encodings and FSM state encodings (ST_MUL only with RV32M_MUL_EN)
package exec_stage_pkg;
  localparam int WORD_LEN = 32;
  localparam int ADDR_LEN = 5;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef RV32M_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/exec_stage_alu.sv
// alu_comb: combinational single-cycle op evaluator; MUL and unknown ops report illegal with a zero result
module alu_comb
  import exec_stage_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  output logic [WORD_LEN-1:0] y,
  output logic                illegal
);
  always_comb begin
    y = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = $signed(a) >>> b[4:0];
      ALU_SLT:   y = {{(WORD_LEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {{(WORD_LEN-1){1'b0}}, a < b};
      ALU_PASSB: y = b;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage with valid/ready handshake, single-cycle ALU and iterative MUL under RV32M_MUL_EN
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          op,
  input  logic [WORD_LEN-1:0] rs1_data,
  input  logic [WORD_LEN-1:0] rs2_data,
  input  logic [WORD_LEN-1:0] imm,
  input  logic                use_imm,
  input  logic [ADDR_LEN-1:0] wb_addr_in,
  input  logic                wb_en_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] alu_out,
  output logic [ADDR_LEN-1:0] wb_addr_out,
  output logic                wb_en_out,
  output logic                illegal
);
  state_e state, state_nx;
  logic [WORD_LEN-1:0] opb, alu_y;
  logic alu_ill, accept, is_mul, bad;
  assign opb = use_imm ? imm : rs2_data;
  assign accept = in_valid && in_ready;
  alu_comb u_alu (.op(op), .a(rs1_data), .b(opb), .y(alu_y), .illegal(alu_ill));
`ifdef RV32M_MUL_EN
  logic [5:0] cnt;
  logic [WORD_LEN-1:0] ma, mb;
  assign is_mul = op == ALU_MUL;
`else
  assign is_mul = 1'b0;
`endif
  assign bad = alu_ill && !is_mul;
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
`ifdef RV32M_MUL_EN
      ST_IDLE: state_nx = accept ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
      ST_MUL:  state_nx = cnt == 6'd31 ? ST_DONE : ST_MUL;
`else
      ST_IDLE: state_nx = accept ? ST_DONE : ST_IDLE;
`endif
      ST_DONE: state_nx = out_ready ? ST_IDLE : ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end
  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      wb_addr_out <= '0;
      wb_en_out <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      alu_out <= alu_y;
      wb_addr_out <= wb_addr_in;
      wb_en_out <= wb_en_in && wb_addr_in != '0 && !bad;
      illegal <= bad;
`ifdef RV32M_MUL_EN
      cnt <= '0;
      ma <= rs1_data;
      mb <= opb;
    end else if (state == ST_MUL) begin
      alu_out <= alu_out + (mb[0] ? ma : '0);
      ma <= ma << 1;
      mb <= mb >> 1;
      cnt <= cnt + 6'd1;
`endif
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed self-checking bench for exec_stage (MUL checks follow RV32M_MUL_EN)
module tb_exec_stage;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, use_imm, wb_en_in, out_valid, out_ready, wb_en_out, illegal;
  logic [3:0] op;
  logic [31:0] rs1_data, rs2_data, imm, alu_out;
  logic [4:0] wb_addr_in, wb_addr_out;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
    .wb_addr_in(wb_addr_in), .wb_en_in(wb_en_in), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .wb_addr_out(wb_addr_out), .wb_en_out(wb_en_out), .illegal(illegal)
  );

  task automatic issue(input logic [3:0] o, input logic [31:0] a, b, input logic ui,
                       input logic [31:0] im, input logic [4:0] wa, input logic we);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL issue_wait: in_ready %b after %0d cycles, need 1", in_ready, t); end
    op = o; rs1_data = a; rs2_data = b; use_imm = ui; imm = im; wb_addr_in = wa; wb_en_in = we;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    n_checks++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL rst_alu_out: got %h need 0", alu_out); end
    n_checks++; if (wb_addr_out !== 5'd0) begin n_fail++; $display("FAIL rst_wb_addr: got %h need 0", wb_addr_out); end
    n_checks++; if (wb_en_out !== 1'b0) begin n_fail++; $display("FAIL rst_wb_en: got %b need 0", wb_en_out); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %b need 0", illegal); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_add;
    issue(4'd0, 32'd5, 32'd7, 1'b0, 32'h0000_0BAD, 5'd3, 1'b1);
    rs1_data = 32'h1111_1111; rs2_data = 32'h2222_2222;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b need 1", out_valid); end
    n_checks++; if (alu_out !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h need %h", alu_out, 32'd12); end
    n_checks++; if (wb_addr_out !== 5'd3 || wb_en_out !== 1'b1) begin n_fail++; $display("FAIL add_wb: got %h/%b need 03/1", wb_addr_out, wb_en_out); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy: in_ready %b need 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL add_return: in_ready %b out_valid %b need 1/0", in_ready, out_valid); end
  endtask

  task automatic test_alu_ops;
    logic [3:0]  ops[11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0};
    logic [31:0] as[11] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hFF00, 32'd1, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] bs[11] = '{32'd7, 32'hFF00, 32'h0F0F, 32'h0FF0, 32'h24, 32'd4, 32'd4,
                            32'd1, 32'd1, 32'h1234_5678, 32'd2};
    logic        ui[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex[11] = '{32'hFFFF_FFFE, 32'hF000, 32'hFFFF, 32'hF0F0, 32'h10, 32'h0800_0000,
                            32'hF800_0000, 32'd1, 32'd0, 32'h1234_5678, 32'd1};
    for (int i = 0; i < 11; i++) begin
      issue(ops[i], as[i], ui[i] ? 32'hDEAD_BEEF : bs[i], ui[i], ui[i] ? bs[i] : 32'h0000_0BAD, 5'd9, 1'b1);
      n_checks++; if (alu_out !== ex[i] || illegal !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL alu_op%0d: got %h ill %b ov %b need %h ill 0 ov 1", ops[i], alu_out, illegal, out_valid, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul;
    int i = 1;
`ifdef RV32M_MUL_EN
    issue(4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h0000_0BAD, 5'd4, 1'b1);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_busy: in_ready %b out_valid %b need 0/0", in_ready, out_valid); end
    while (out_valid !== 1'b1 && i < 40) begin
      @(posedge clk); #1; i++;
    end
    n_checks++; if (i != 33) begin n_fail++; $display("FAIL mul_latency: out_valid at T+%0d need T+33", i); end
    n_checks++; if (alu_out !== 32'hFFFF_FFFD || illegal !== 1'b0 || wb_en_out !== 1'b1) begin
      n_fail++; $display("FAIL mul_result: got %h ill %b wb_en %b need fffffffd ill 0 wb_en 1", alu_out, illegal, wb_en_out);
    end
`else
    issue(4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h0000_0BAD, 5'd4, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL mul_illegal: ov %b ill %b at T+%0d need 1/1", out_valid, illegal, i); end
    n_checks++; if (alu_out !== 32'h0 || wb_en_out !== 1'b0) begin n_fail++; $display("FAIL mul_off_result: got %h wb_en %b need 0/0", alu_out, wb_en_out); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    issue(4'd4, 32'hFF00, 32'h0FF0, 1'b0, 32'h0000_0BAD, 5'd6, 1'b1);
    for (int k = 0; k < 5; k++) begin
      op = 4'd0; rs1_data = k; rs2_data = 32'd100; wb_addr_in = 5'd1; in_valid = (k % 2) == 0;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_hs_%0d: ov %b in_ready %b need 1/0", k, out_valid, in_ready); end
      n_checks++; if (alu_out !== 32'hF0F0 || wb_addr_out !== 5'd6) begin n_fail++; $display("FAIL hold_data_%0d: got %h/%h need f0f0/06", k, alu_out, wb_addr_out); end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: ov %b in_ready %b need 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_accept: ov %b need 0", out_valid); end
  endtask

  task automatic test_reset_midop;
    int seen = 0;
`ifdef RV32M_MUL_EN
    issue(4'd11, 32'd9, 32'd9, 1'b0, 32'h0000_0BAD, 5'd2, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 32'h0) begin
      n_fail++; $display("FAIL rst_mul: ov %b in_ready %b alu %h need 0/1/0", out_valid, in_ready, alu_out);
    end
`endif
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 1'b0, 32'h0000_0BAD, 5'd2, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_discard: %0d out_valid cycles need 0", seen); end
    issue(4'd0, 32'd1, 32'd1, 1'b0, 32'h0000_0BAD, 5'd2, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || alu_out !== 32'd2) begin n_fail++; $display("FAIL rst_then_add: ov %b alu %h need 1/2", out_valid, alu_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_wb;
    issue(4'd0, 32'd1, 32'd2, 1'b0, 32'h0000_0BAD, 5'd0, 1'b1);
    n_checks++; if (wb_en_out !== 1'b0 || wb_addr_out !== 5'd0 || alu_out !== 32'd3) begin
      n_fail++; $display("FAIL wb_x0: wb_en %b addr %h alu %h need 0/00/3", wb_en_out, wb_addr_out, alu_out);
    end
    @(posedge clk); #1;
    issue(4'd0, 32'd1, 32'd2, 1'b0, 32'h0000_0BAD, 5'd5, 1'b0);
    n_checks++; if (wb_en_out !== 1'b0 || wb_addr_out !== 5'd5) begin n_fail++; $display("FAIL wb_off: wb_en %b addr %h need 0/05", wb_en_out, wb_addr_out); end
    @(posedge clk); #1;
    issue(4'hF, 32'd5, 32'd6, 1'b0, 32'h0000_0BAD, 5'd7, 1'b1);
    n_checks++; if (illegal !== 1'b1 || alu_out !== 32'h0 || wb_en_out !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL op_undef: ill %b alu %h wb_en %b ov %b need 1/0/0/1", illegal, alu_out, wb_en_out, out_valid);
    end
    @(posedge clk); #1;
    issue(4'd3, 32'h0F00, 32'h00F0, 1'b0, 32'h0000_0BAD, 5'd7, 1'b1);
    n_checks++; if (illegal !== 1'b0 || alu_out !== 32'h0FF0 || wb_en_out !== 1'b1) begin
      n_fail++; $display("FAIL after_undef: ill %b alu %h wb_en %b need 0/0ff0/1", illegal, alu_out, wb_en_out);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; use_imm = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; wb_addr_in = '0; wb_en_in = 1'b0;
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_hold();
    test_reset_midop();
    test_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
